// File: rtl/char_rot_pkg.sv
// rtl/char_rot_pkg.sv - shared types, widths and wrap arithmetic for char_rotator
package char_rot_pkg;

    // Width of one select code driving s2,s1,s0 of a downstream selector.
    localparam int SEL_WIDTH = 3;

    typedef enum logic [0:0] {
        STOP = 1'b0,
        RUN  = 1'b1
    } rot_state_e;

    // Wraps value into 0..num_disp-1. Callers only ever pass values in
    // -num_disp..2*num_disp-1 (offset+/-1 or index+offset), so a single
    // conditional add/subtract replaces a real modulo operator.
    function automatic logic [SEL_WIDTH-1:0] rot_mod(input int value, input int num_disp);
        int r;
        r = value;
        if (r >= num_disp) begin
            r = r - num_disp;
        end else if (r < 0) begin
            r = r + num_disp;
        end
        return SEL_WIDTH'(r);
    endfunction

endpackage

// File: rtl/rot_prescaler.sv
// rtl/rot_prescaler.sv - free-running advance prescaler, held at zero while disabled
module rot_prescaler #(
    parameter int PRESCALE = 50_000_000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] count;

    // Tick is combinational on the terminal count so the advance it causes
    // lands on the same edge that wraps the counter.
    assign tick = en && (count == LAST);

    // Count only while enabled; clearing while disabled makes every
    // enable start a fresh full period.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (!en || tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/char_rotator.sv
// rtl/char_rotator.sv - scrolling select-code generator (optional macro ROT_STEP_SYNC_EN)
module char_rotator
    import char_rot_pkg::*;
#(
    parameter int NUM_DISP = 5,
    parameter int PRESCALE = 50_000_000
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          Run,
    input  logic                          Step,
    input  logic                          Dir,
    output logic [NUM_DISP*SEL_WIDTH-1:0] sel_bus,
    output logic [SEL_WIDTH-1:0]          offset,
    output logic                          adv
);

    rot_state_e           state;
    logic                 tick;
    logic                 step_req;
    logic                 advance;
    logic [SEL_WIDTH-1:0] offset_next;

    rot_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .Clock(Clock),
        .Reset(Reset),
        .en   (state == RUN),
        .tick (tick)
    );

`ifdef ROT_STEP_SYNC_EN
    logic step_meta;
    logic step_sync;
    logic step_prev;

    // Two-flop synchroniser, rising-edge detect, then a registered request
    // so a press of any length yields exactly one advance three edges later.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            step_meta <= 1'b0;
            step_sync <= 1'b0;
            step_prev <= 1'b0;
            step_req  <= 1'b0;
        end else begin
            step_meta <= Step;
            step_sync <= step_meta;
            step_prev <= step_sync;
            step_req  <= step_sync & ~step_prev;
        end
    end
`else
    // Step is already a clean synchronous pulse; a held Step advances every cycle.
    assign step_req = Step;
`endif

    // Select the advance source for the current state and compute the next offset.
    always_comb begin
        advance     = 1'b0;
        offset_next = offset;
        if (state == RUN) begin
            advance = tick;
        end else begin
            advance = step_req;
        end
        if (advance) begin
            if (Dir) begin
                offset_next = rot_mod(int'(offset) - 1, NUM_DISP);
            end else begin
                offset_next = rot_mod(int'(offset) + 1, NUM_DISP);
            end
        end
    end

    // RUN/STOP follows the Run level; an advance decided this cycle is taken
    // regardless of the transition, so simultaneous events need no special case.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= STOP;
        end else begin
            case (state)
                STOP:    if (Run)  state <= RUN;
                RUN:     if (!Run) state <= STOP;
                default: state <= STOP;
            endcase
        end
    end

    // Offset register and its one-cycle change strobe.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            offset <= '0;
            adv    <= 1'b0;
        end else begin
            offset <= offset_next;
            adv    <= advance;
        end
    end

    // Per-display select codes, registered from the next offset so they
    // change on the same edge as offset and adv.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_DISP; i++) begin
                sel_bus[i*SEL_WIDTH +: SEL_WIDTH] <= SEL_WIDTH'(i);
            end
        end else begin
            for (int i = 0; i < NUM_DISP; i++) begin
                sel_bus[i*SEL_WIDTH +: SEL_WIDTH] <= rot_mod(i + int'(offset_next), NUM_DISP);
            end
        end
    end

endmodule
